// File: rtl/picomips_ctrl.sv
// picomips_ctrl: picoMIPS instruction sequencer, PC, decode, branch and MULI stall control
module picomips_ctrl #(
  parameter int Psize   = 5,
  parameter int Isize   = 14,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             en,
  input  logic             btn,
  input  logic [Isize-1:0] I,
  output logic [Psize-1:0] pc,
  output logic [1:0]       alu_op,
  output logic [1:0]       rd,
  output logic [1:0]       rs,
  output logic [7:0]       imm,
  output logic             in_sel,
  output logic             we,
  output logic             mul_start,
  output logic             busy
);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  localparam int CI = MUL_LAT > 0 ? MUL_LAT - 1 : 0;
  typedef enum logic {RUN, MUL_WAIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [Psize-1:0] pc_n;
  logic btn_m, btn_s, we_i, ms_i;
  assign alu_op    = I[13:12];
  assign rd        = I[11:10];
  assign rs        = I[9:8];
  assign imm       = I[7:0];
  assign in_sel    = (alu_op == 2'b00) & I[7];
  assign we        = we_i & nReset;
  assign mul_start = ms_i & nReset;
  assign busy      = (state == MUL_WAIT) & nReset;
  // Next PC/state and write strobes; everything holds when en is low
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    we_i    = 1'b0;
    ms_i    = 1'b0;
    if (en) begin
      if (state == MUL_WAIT) begin
        if (cnt == '0) begin
          we_i    = 1'b1;
          pc_n    = pc + 1'b1;
          state_n = RUN;
        end else cnt_n = cnt - 1'b1;
      end else if (alu_op == 2'b11) pc_n = (btn_s == I[7]) ? I[Psize-1:0] : pc + 1'b1;
      else if (alu_op == 2'b10 && MUL_LAT > 0) begin
        ms_i    = 1'b1;
        cnt_n   = CW'(CI);
        state_n = MUL_WAIT;
      end else begin
        we_i = 1'b1;
        pc_n = pc + 1'b1;
      end
    end
  end
  // State registers and the two-flop button synchroniser
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc    <= '0;
      state <= RUN;
      cnt   <= '0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      pc    <= pc_n;
      state <= state_n;
      cnt   <= cnt_n;
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end
endmodule

// File: tb/tb_picomips_ctrl.sv
// tb_picomips_ctrl: scoreboard bench for picomips_ctrl (MUL_LAT=2 and MUL_LAT=0 instances)
module tb_picomips_ctrl;
  localparam int S_PC = 0, S_WE = 1, S_MS = 2, S_BUSY = 3, S_INSEL = 4, S_ALU = 5,
                 S_RD = 6, S_RS = 7, S_IMM = 8, S_PCB = 9, S_WEB = 10, S_MSB = 11, S_BUSYB = 12;
  localparam logic [13:0] ADD = 14'h0080;
  typedef struct {string name; int sig; int val;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic clk = 0, nreset, en, btn;
  logic [13:0] instr, instr_b;
  logic [4:0] pc, pc_b;
  logic [1:0] alu_op, rd, rs, alu_op_b, rd_b, rs_b;
  logic [7:0] imm, imm_b;
  logic in_sel, we, mul_start, busy, in_sel_b, we_b, mul_start_b, busy_b;
  picomips_ctrl #(.Psize(5), .Isize(14), .MUL_LAT(2)) dut (
    .clk(clk), .nReset(nreset), .en(en), .btn(btn), .I(instr), .pc(pc), .alu_op(alu_op),
    .rd(rd), .rs(rs), .imm(imm), .in_sel(in_sel), .we(we), .mul_start(mul_start), .busy(busy));
  picomips_ctrl #(.Psize(5), .Isize(14), .MUL_LAT(0)) dut_b (
    .clk(clk), .nReset(nreset), .en(1'b1), .btn(1'b0), .I(instr_b), .pc(pc_b), .alu_op(alu_op_b),
    .rd(rd_b), .rs(rs_b), .imm(imm_b), .in_sel(in_sel_b), .we(we_b), .mul_start(mul_start_b),
    .busy(busy_b));
  always #5 clk = ~clk;
  function automatic int get(input int s);
    case (s)
      S_PC:    return int'(pc);
      S_WE:    return int'(we);
      S_MS:    return int'(mul_start);
      S_BUSY:  return int'(busy);
      S_INSEL: return int'(in_sel);
      S_ALU:   return int'(alu_op);
      S_RD:    return int'(rd);
      S_RS:    return int'(rs);
      S_IMM:   return int'(imm);
      S_PCB:   return int'(pc_b);
      S_WEB:   return int'(we_b);
      S_MSB:   return int'(mul_start_b);
      S_BUSYB: return int'(busy_b);
      default: return -1;
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      int a;
      e = q.pop_front();
      a = get(e.sig);
      tests++;
      if (a != e.val) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.name, a, e.val, $time);
      end
    end
  end
  task automatic drv(input logic [13:0] i, input logic e, input logic b);
    instr = i;
    en = e;
    btn = b;
  endtask
  task automatic chk(input string n, input int s, input int v);
    q.push_back('{n, s, v});
  endtask
  task automatic now(input string n, input int s, input int v);
    int a;
    a = get(s);
    tests++;
    if (a != v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, v, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    nreset = 0;
    instr_b = ADD;
    drv(ADD, 1, 0);
    tick();
    now("rst_now_pc", S_PC, 0);
    now("rst_now_busy", S_BUSY, 0);
    for (int k = 0; k < 2; k++) begin
      chk("rst_pc", S_PC, 0); chk("rst_we", S_WE, 0); chk("rst_busy", S_BUSY, 0);
      chk("rst_ms", S_MS, 0); chk("rst_pc_b", S_PCB, 0); chk("rst_we_b", S_WEB, 0);
      tick();
    end
    nreset = 1;
    for (int k = 0; k < 4; k++) begin
      chk("run_pc", S_PC, k); chk("run_we", S_WE, 1); chk("run_in_sel", S_INSEL, 1);
      tick();
    end
    drv(14'h3001, 1, 0); chk("jmp1_pc", S_PC, 4); chk("b_we", S_WE, 0); tick();
    for (int k = 0; k < 10; k++) begin
      chk("wait_btn_pc", S_PC, 1); chk("wait_btn_we", S_WE, 0); tick();
    end
    for (int k = 0; k < 3; k++) begin
      drv(14'h3001, 1, 1); chk("btn_sync_pc", S_PC, 1); tick();
    end
    now("wait_expired_pc", S_PC, 2);
    drv(ADD, 1, 1); chk("btn_rel_pc", S_PC, 2); tick();
    chk("add_pc3", S_PC, 3); tick();
    drv(14'h3084, 1, 1);
    for (int k = 0; k < 4; k++) begin
      chk("wait_rel_pc", S_PC, 4); tick();
    end
    for (int k = 0; k < 3; k++) begin
      drv(14'h3084, 1, 0); chk("rel_sync_pc", S_PC, 4); tick();
    end
    drv(14'h3009, 1, 0); chk("rel_adv_pc", S_PC, 5); tick();
    drv(14'h2060, 1, 0);
    chk("mul0_pc", S_PC, 9); chk("mul0_ms", S_MS, 1); chk("mul0_busy", S_BUSY, 0); chk("mul0_we", S_WE, 0);
    tick();
    chk("mul1_pc", S_PC, 9); chk("mul1_busy", S_BUSY, 1); chk("mul1_we", S_WE, 0); chk("mul1_ms", S_MS, 0);
    tick();
    chk("mul2_pc", S_PC, 9); chk("mul2_busy", S_BUSY, 1); chk("mul2_we", S_WE, 1); tick();
    chk("mul3_pc", S_PC, 10); chk("mul3_busy", S_BUSY, 0); chk("mul3_ms", S_MS, 1); tick();
    drv(14'h2060, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("en0_pc", S_PC, 10); chk("en0_busy", S_BUSY, 1); chk("en0_we", S_WE, 0); chk("en0_ms", S_MS, 0);
      tick();
    end
    drv(14'h2060, 1, 0);
    chk("en1_busy", S_BUSY, 1); chk("en1_we", S_WE, 0); chk("en1_pc", S_PC, 10); tick();
    chk("en1_fin_busy", S_BUSY, 1); chk("en1_fin_we", S_WE, 1); tick();
    chk("mulr_pc", S_PC, 11); chk("mulr_ms", S_MS, 1); tick();
    chk("mulr_busy", S_BUSY, 1); chk("mulr_pc1", S_PC, 11); tick();
    nreset = 0;
    chk("abort_pc", S_PC, 0); chk("abort_busy", S_BUSY, 0); chk("abort_we", S_WE, 0); chk("abort_ms", S_MS, 0);
    tick();
    nreset = 1;
    drv(ADD, 1, 0); chk("post_rst_pc", S_PC, 0); chk("post_rst_we", S_WE, 1); chk("post_rst_busy", S_BUSY, 0);
    tick();
    drv(14'h301F, 1, 0); chk("jmp31_pc", S_PC, 1); tick();
    drv(14'h1000, 1, 0); chk("wrap_pc31", S_PC, 31); chk("addi_we", S_WE, 1); chk("addi_alu", S_ALU, 1);
    tick();
    drv(ADD, 1, 1); chk("wrap_pc0", S_PC, 0); tick();
    tick();
    tick();
    drv(14'h30F4, 1, 1); chk("tgt_pc3", S_PC, 3); chk("tgt_we", S_WE, 0); chk("tgt_alu", S_ALU, 3);
    chk("tgt_imm", S_IMM, 8'hF4); tick();
    drv(14'h1B05, 1, 1); chk("tgt_pc20", S_PC, 20); chk("dec_alu", S_ALU, 1); chk("dec_rd", S_RD, 2);
    chk("dec_rs", S_RS, 3); chk("dec_imm", S_IMM, 5); chk("dec_in_sel", S_INSEL, 0); chk("dec_we", S_WE, 1);
    tick();
    drv(14'h0603, 1, 1); chk("dec2_pc", S_PC, 21); chk("dec2_alu", S_ALU, 0); chk("dec2_rd", S_RD, 1);
    chk("dec2_rs", S_RS, 2); chk("dec2_in_sel", S_INSEL, 0); tick();
    instr_b = 14'h3009; tick();
    instr_b = 14'h2060;
    chk("mul_lat0_pc", S_PCB, 9); chk("mul_lat0_we", S_WEB, 1); chk("mul_lat0_ms", S_MSB, 0);
    chk("mul_lat0_busy", S_BUSYB, 0); tick();
    instr_b = ADD; chk("mul_lat0_next_pc", S_PCB, 10); tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
